// File: rtl/disp_scan_ctrl_if.sv
// Shared-display scan bus: BCD digit inputs and enable in, multiplexed digit drive out.
interface disp_scan_ctrl_if;
   logic       en;
   logic [3:0] one1;
   logic [3:0] ten1;
   logic [3:0] one2;
   logic [3:0] ten2;
   logic [3:0] bcd_out;
   logic [3:0] an_n;
   logic [1:0] digit_idx;
   logic       frame_tick;

   modport slave (
      input  en, one1, ten1, one2, ten2,
      output bcd_out, an_n, digit_idx, frame_tick
   );

   modport master (
      output en, one1, ten1, one2, ten2,
      input  bcd_out, an_n, digit_idx, frame_tick
   );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexes four countdown digits onto one shared
// BCD-to-7-segment decoder with a dark interval before every digit.
// Optional build macro DISP_LZ_BLANK_EN: a tens digit of 0 keeps its slot dark.
module disp_scan_ctrl #(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic              clk,
   input  logic              rst_n,
   disp_scan_ctrl_if.slave   io_bus
);

   localparam int unsigned MAX_CYC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]       r_idx, w_idx_nxt, w_idx_inc;
   logic [3:0][3:0]  r_snap, w_snap_nxt, w_inputs;
   logic [3:0]       r_bcd, w_bcd_nxt;
   logic [3:0]       r_an_n, w_an_n_nxt, w_an_sel;
   logic             r_tick, w_tick_nxt;
   logic             w_lz;

   // Element 0 is one1, matching the digit index order.
   assign w_inputs  = {io_bus.ten2, io_bus.one2, io_bus.ten1, io_bus.one1};
   assign w_idx_inc = r_idx + 2'd1;
   assign w_an_sel  = ~(4'b0001 << r_idx);

`ifdef DISP_LZ_BLANK_EN
   // Tens slots (odd index) holding 0 stay dark but keep their timing.
   assign w_lz = r_idx[0] && (r_snap[r_idx] == 4'd0);
`else
   assign w_lz = 1'b0;
`endif

   // Next-state, counter, snapshot and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_idx_nxt   = r_idx;
      w_snap_nxt  = r_snap;
      w_bcd_nxt   = r_bcd;
      w_an_n_nxt  = 4'b1111;
      w_tick_nxt  = 1'b0;

      if (!io_bus.en) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt = S_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 2'd0;
               w_snap_nxt  = w_inputs;
               w_bcd_nxt   = w_inputs[0];
            end
            S_BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_state_nxt = S_SHOW;
                  w_cnt_nxt   = '0;
                  if (!w_lz) w_an_n_nxt = w_an_sel;
               end
            end
            S_SHOW: begin
               if (r_cnt == SHOW_LAST) begin
                  w_state_nxt = S_BLANK;
                  w_cnt_nxt   = '0;
                  if (r_idx == 2'd3) begin
                     w_idx_nxt  = 2'd0;
                     w_tick_nxt = 1'b1;
                     w_snap_nxt = w_inputs;
                     w_bcd_nxt  = w_inputs[0];
                  end else begin
                     w_idx_nxt = w_idx_inc;
                     w_bcd_nxt = r_snap[w_idx_inc];
                  end
               end else if (!w_lz) begin
                  w_an_n_nxt = w_an_sel;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 2'd0;
            end
         endcase
      end
   end

   // State and registered outputs; reset darkens the anodes without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
         r_snap  <= '0;
         r_bcd   <= 4'd0;
         r_an_n  <= 4'b1111;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_snap  <= w_snap_nxt;
         r_bcd   <= w_bcd_nxt;
         r_an_n  <= w_an_n_nxt;
         r_tick  <= w_tick_nxt;
      end
   end

   assign io_bus.bcd_out    = r_bcd;
   assign io_bus.an_n       = r_an_n;
   assign io_bus.digit_idx  = r_idx;
   assign io_bus.frame_tick = r_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position reference model feeding a per-cycle
// scoreboard, plus anode/bcd invariant and frame_tick count checks.
module tb_disp_scan_ctrl;

   localparam int DIV   = 4;
   localparam int BLANK = 1;
   localparam int P     = BLANK + DIV;
   localparam int FRAME = 4 * P;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] bcd;
      logic [1:0] idx;
      logic       tick;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   ticks  = 0;
   exp_t sb_q[$];

   disp_scan_ctrl_if dif();

   disp_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYC(BLANK)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (dif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: position within the frame decides slot and phase.
   initial begin
      logic [3:0] m_snap [4];
      logic [3:0] m_bcd;
      bit         m_run;
      int         m_t, slot, sub;
      exp_t       e;
      logic       wrap;
      m_run = 0; m_t = 0; m_bcd = 4'd0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_run = 0; m_t = 0; m_bcd = 4'd0;
            for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
            sb_q.delete();
         end else begin
            wrap = 1'b0;
            if (!dif.en) begin
               m_run = 0; m_t = 0;
            end else if (!m_run) begin
               m_run = 1; m_t = 0;
               m_snap[0] = dif.one1; m_snap[1] = dif.ten1;
               m_snap[2] = dif.one2; m_snap[3] = dif.ten2;
            end else begin
               m_t++;
               if (m_t == FRAME) begin
                  m_t = 0; wrap = 1'b1;
                  m_snap[0] = dif.one1; m_snap[1] = dif.ten1;
                  m_snap[2] = dif.one2; m_snap[3] = dif.ten2;
               end
            end
            e.an = 4'hF; e.idx = 2'd0; e.tick = wrap;
            if (m_run) begin
               slot  = m_t / P;
               sub   = m_t % P;
               e.idx = 2'(slot);
               m_bcd = m_snap[slot];
               if (sub >= BLANK) begin
                  e.an = 4'hF ^ (4'h1 << slot);
`ifdef DISP_LZ_BLANK_EN
                  if ((slot % 2 == 1) && (m_snap[slot] == 4'd0)) e.an = 4'hF;
`endif
               end
            end
            e.bcd = m_bcd;
            sb_q.push_back(e);
         end
      end
   end

   // Checker: pops expectations and watches the display invariants.
   initial begin
      exp_t       e;
      logic [3:0] prev_an, prev_bcd;
      prev_an = 4'hF; prev_bcd = 4'd0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_an", 32'(dif.an_n), 32'hF);
            chk("rst_bcd", 32'(dif.bcd_out), 32'h0);
            chk("rst_idx", 32'(dif.digit_idx), 32'h0);
            chk("rst_tick", 32'(dif.frame_tick), 32'h0);
         end else begin
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("an_n", 32'(dif.an_n), 32'(e.an));
               chk("bcd_out", 32'(dif.bcd_out), 32'(e.bcd));
               chk("digit_idx", 32'(dif.digit_idx), 32'(e.idx));
               chk("frame_tick", 32'(dif.frame_tick), 32'(e.tick));
            end
            chk("one_anode", 32'($countones(~dif.an_n) <= 1), 32'h1);
            if (prev_an != 4'hF && dif.an_n != 4'hF)
               chk("bcd_stable", 32'(dif.bcd_out), 32'(prev_bcd));
         end
         if (dif.frame_tick === 1'b1) ticks++;
         prev_an  = dif.an_n;
         prev_bcd = dif.bcd_out;
      end
   end

   task automatic set_digits(input logic [3:0] o1, input logic [3:0] t1,
                             input logic [3:0] o2, input logic [3:0] t2);
      dif.one1 = o1; dif.ten1 = t1; dif.one2 = o2; dif.ten2 = t2;
   endtask

   // Directed and random stimulus.
   initial begin
      int  t0;
      bit  found;
      dif.en = 1'b0;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic scan with a snapshot change during idx2 of the second frame.
      set_digits(4'd5, 4'd2, 4'd7, 4'd3);
      dif.en = 1'b1;
      repeat (FRAME + 11) @(negedge clk);
      dif.one1 = 4'd9;
      repeat (2 * FRAME) @(negedge clk);

      // Drop enable while digit 1 is lit, then restart.
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (dif.digit_idx == 2'd1 && dif.an_n == 4'b1101) found = 1;
      end
      chk("wait_idx1_show", 32'(found), 32'h1);
      dif.en = 1'b0;
      repeat (3) @(negedge clk);
      dif.en = 1'b1;
      repeat (12) @(negedge clk);

      // Asynchronous reset while a digit is lit.
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (dif.an_n != 4'hF) found = 1;
      end
      chk("wait_show", 32'(found), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_an", 32'(dif.an_n), 32'hF);
      chk("async_bcd", 32'(dif.bcd_out), 32'h0);
      chk("async_idx", 32'(dif.digit_idx), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Zero tens digit on road 1.
      set_digits(4'd6, 4'd0, 4'd1, 4'd4);
      repeat (2 * FRAME + 3) @(negedge clk);

      // Long random run counting frame ticks.
      dif.en = 1'b0;
      @(negedge clk);
      #1;
      t0 = ticks;
      dif.en = 1'b1;
      repeat (100 * FRAME + 1) begin
         @(negedge clk);
         set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      #1;
      chk("tick_count", 32'(ticks - t0), 32'd100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
